// File: rtl/mod_counter_pd_if.sv
// Bundles the control and status signals of mod_counter_pd.
//   master: drives en, up, load, load_val; observes count, tick, co, tc, bcd_tens, bcd_ones
//   slave : the counter side (mirror image)
// WIDTH must match the WIDTH of the attached counter.
interface mod_counter_pd_if #(
  parameter int unsigned WIDTH = 6
);
  logic             en;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] count;
  logic             tick;
  logic             co;
  logic             tc;
  logic [3:0]       bcd_tens;
  logic [3:0]       bcd_ones;

  modport master (
    output en, up, load, load_val,
    input  count, tick, co, tc, bcd_tens, bcd_ones
  );

  modport slave (
    input  en, up, load, load_val,
    output count, tick, co, tc, bcd_tens, bcd_ones
  );
endinterface

// File: rtl/mod_counter_pd.sv
// Parametrised modulo-MODULUS up/down counter with prescaler, parallel load
// and a registered carry/borrow pulse for cascading.
//
// Ports:
//   clk        system clock, all state on rising edge
//   rst        synchronous active-high reset
//   bus.en       count enable (advances the prescaler)
//   bus.up       1 = increment, 0 = decrement
//   bus.load     synchronous parallel load (beats en)
//   bus.load_val value to load, saturated to MODULUS-1
//   bus.count    registered count
//   bus.tick     registered, high on the cycle count stepped
//   bus.co       registered carry (up wrap) / borrow (down wrap) pulse
//   bus.tc       combinational terminal count for the current direction
//   bus.bcd_tens/bcd_ones  decimal digits of count
//
// Optional feature: define MOD_COUNTER_BCD_EN to keep registered decimal
// digits of count (MODULUS <= 100). Otherwise the digit outputs are 0.
module mod_counter_pd #(
  parameter int unsigned MODULUS = 60,
  parameter int unsigned WIDTH   = 6,
  parameter int unsigned DIV     = 1,
  parameter int unsigned PW      = 8
) (
  input logic             clk,
  input logic             rst,
  mod_counter_pd_if.slave bus
);

  localparam logic [WIDTH-1:0] MAX_VAL  = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   MOD_EXT  = (WIDTH+1)'(MODULUS);
  localparam logic [PW-1:0]    PRE_LAST = PW'(DIV - 1);

  if (MODULUS < 2) begin : g_chk_mod
    $error("mod_counter_pd: MODULUS must be >= 2");
  end
  if ((64'd1 << WIDTH) < 64'(MODULUS)) begin : g_chk_width
    $error("mod_counter_pd: WIDTH too small for MODULUS");
  end
  if (DIV < 1) begin : g_chk_div
    $error("mod_counter_pd: DIV must be >= 1");
  end
  if ((64'd1 << PW) < 64'(DIV)) begin : g_chk_pw
    $error("mod_counter_pd: PW too small for DIV");
  end

  logic [WIDTH-1:0] count_q;
  logic [PW-1:0]    pre_q;
  logic             tick_q;
  logic             co_q;

  logic [WIDTH-1:0] load_sat;
  logic [WIDTH-1:0] step_val;
  logic             wrap;
  logic             step;

  // Extended compare so MODULUS == 2^WIDTH still works.
  assign load_sat = ({1'b0, bus.load_val} < MOD_EXT) ? bus.load_val : MAX_VAL;
  assign step     = bus.en && (pre_q == PRE_LAST);

  always_comb begin
    wrap     = 1'b0;
    step_val = count_q;
    if (bus.up) begin
      // >= so an out-of-range count also wraps to 0 with carry.
      wrap     = (count_q >= MAX_VAL);
      step_val = wrap ? '0 : count_q + 1'b1;
    end else begin
      wrap     = (count_q == '0);
      step_val = wrap ? MAX_VAL : count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      pre_q   <= '0;
      tick_q  <= 1'b0;
      co_q    <= 1'b0;
    end else if (bus.load) begin
      count_q <= load_sat;
      pre_q   <= '0;
      tick_q  <= 1'b0;
      co_q    <= 1'b0;
    end else if (bus.en) begin
      tick_q <= step;
      co_q   <= step && wrap;
      if (step) begin
        pre_q   <= '0;
        count_q <= step_val;
      end else begin
        pre_q <= pre_q + 1'b1;
      end
    end else begin
      tick_q <= 1'b0;
      co_q   <= 1'b0;
    end
  end

  assign bus.count = count_q;
  assign bus.tick  = tick_q;
  assign bus.co    = co_q;
  assign bus.tc    = (bus.up && (count_q == MAX_VAL)) || (!bus.up && (count_q == '0));

`ifdef MOD_COUNTER_BCD_EN
  if (MODULUS > 100) begin : g_chk_bcd
    $error("mod_counter_pd: BCD digits need MODULUS <= 100");
  end

  localparam logic [3:0] MAX_TENS = 4'((MODULUS - 1) / 10);
  localparam logic [3:0] MAX_ONES = 4'((MODULUS - 1) % 10);

  function automatic logic [3:0] tens_of(input logic [WIDTH-1:0] v);
    return 4'(32'(v) / 32'd10);
  endfunction

  function automatic logic [3:0] ones_of(input logic [WIDTH-1:0] v);
    return 4'(32'(v) % 32'd10);
  endfunction

  logic [3:0] tens_q;
  logic [3:0] ones_q;

  // Digits follow count incrementally; only a load needs a full conversion.
  always_ff @(posedge clk) begin
    if (rst) begin
      tens_q <= 4'd0;
      ones_q <= 4'd0;
    end else if (bus.load) begin
      tens_q <= tens_of(load_sat);
      ones_q <= ones_of(load_sat);
    end else if (step) begin
      if (bus.up) begin
        if (wrap) begin
          tens_q <= 4'd0;
          ones_q <= 4'd0;
        end else if (ones_q == 4'd9) begin
          tens_q <= tens_q + 4'd1;
          ones_q <= 4'd0;
        end else begin
          ones_q <= ones_q + 4'd1;
        end
      end else begin
        if (wrap) begin
          tens_q <= MAX_TENS;
          ones_q <= MAX_ONES;
        end else if (ones_q == 4'd0) begin
          tens_q <= tens_q - 4'd1;
          ones_q <= 4'd9;
        end else begin
          ones_q <= ones_q - 4'd1;
        end
      end
    end
  end

  assign bus.bcd_tens = tens_q;
  assign bus.bcd_ones = ones_q;
`else
  assign bus.bcd_tens = 4'd0;
  assign bus.bcd_ones = 4'd0;
`endif

endmodule

// File: tb/tb_mod_counter_pd.sv
module tb_mod_counter_pd;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Main counter: MODULUS=60, DIV=1.
  logic m_rst;
  mod_counter_pd_if #(.WIDTH(6)) m_if ();
  mod_counter_pd #(.MODULUS(60), .WIDTH(6), .DIV(1), .PW(8)) u_m (
    .clk (clk),
    .rst (m_rst),
    .bus (m_if.slave)
  );

  // Prescaled counter: DIV=4.
  logic d_rst;
  mod_counter_pd_if #(.WIDTH(6)) d_if ();
  mod_counter_pd #(.MODULUS(60), .WIDTH(6), .DIV(4), .PW(8)) u_d (
    .clk (clk),
    .rst (d_rst),
    .bus (d_if.slave)
  );

  // Cascade: seconds co drives minutes en.
  logic c_rst;
  mod_counter_pd_if #(.WIDTH(6)) s_if ();
  mod_counter_pd_if #(.WIDTH(6)) n_if ();
  mod_counter_pd #(.MODULUS(60), .WIDTH(6), .DIV(1), .PW(8)) u_sec (
    .clk (clk),
    .rst (c_rst),
    .bus (s_if.slave)
  );
  mod_counter_pd #(.MODULUS(60), .WIDTH(6), .DIV(1), .PW(8)) u_min (
    .clk (clk),
    .rst (c_rst),
    .bus (n_if.slave)
  );
  assign n_if.en = s_if.co;

  typedef struct {
    logic       rst;
    logic       en;
    logic       up;
    logic       load;
    logic [5:0] lv;
    int         cnt;
    logic       tick;
    logic       co;
  } vec_t;

  localparam int NVEC = 22;
  vec_t vecs[NVEC];

  function automatic vec_t mk(input logic r, input logic e, input logic u, input logic l,
                              input int lv, input int c, input logic t, input logic o);
    vec_t v;
    v.rst = r; v.en = e; v.up = u; v.load = l; v.lv = 6'(lv);
    v.cnt = c; v.tick = t; v.co = o;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_digits(input string name, input int cnt);
`ifdef MOD_COUNTER_BCD_EN
    chk({name, ".tens"}, int'(m_if.bcd_tens), cnt / 10);
    chk({name, ".ones"}, int'(m_if.bcd_ones), cnt % 10);
`else
    chk({name, ".tens"}, int'(m_if.bcd_tens), 0);
    chk({name, ".ones"}, int'(m_if.bcd_ones), 0);
`endif
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int   exp_c;
    logic exp_co;
    int   pre;
    logic exp_t;
    int   co_pulses;
    logic [1:0] dpat[18];

    m_rst = 1'b1; m_if.en = 1'b0; m_if.up = 1'b1; m_if.load = 1'b0; m_if.load_val = '0;
    d_rst = 1'b1; d_if.en = 1'b0; d_if.up = 1'b1; d_if.load = 1'b0; d_if.load_val = '0;
    c_rst = 1'b1; s_if.en = 1'b0; s_if.up = 1'b1; s_if.load = 1'b0; s_if.load_val = '0;
    n_if.up = 1'b1; n_if.load = 1'b0; n_if.load_val = '0;

    // Reset state.
    cyc();
    chk("rst.count", int'(m_if.count), 0);
    chk("rst.tick", int'(m_if.tick), 0);
    chk("rst.co", int'(m_if.co), 0);
    chk("rst.tc", int'(m_if.tc), 0);
    chk_digits("rst", 0);

    // Up count through a full wrap: 61 steps.
    m_rst = 1'b0; m_if.en = 1'b1; m_if.up = 1'b1;
    exp_c = 0;
    for (int i = 0; i < 61; i++) begin
      cyc();
      exp_co = (exp_c == 59);
      exp_c  = exp_co ? 0 : exp_c + 1;
      chk("up.count", int'(m_if.count), exp_c);
      chk("up.tick", int'(m_if.tick), 1);
      chk("up.co", int'(m_if.co), int'(exp_co));
      chk_digits("up", exp_c);
    end

    // Down count from reset.
    m_rst = 1'b1; m_if.en = 1'b0; m_if.up = 1'b0;
    cyc();
    m_rst = 1'b0;
    #1;
    chk("down.tc0", int'(m_if.tc), 1);
    m_if.en = 1'b1;
    exp_c = 0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      exp_co = (exp_c == 0);
      exp_c  = exp_co ? 59 : exp_c - 1;
      chk("down.count", int'(m_if.count), exp_c);
      chk("down.tick", int'(m_if.tick), 1);
      chk("down.co", int'(m_if.co), int'(exp_co));
      chk("down.tc", int'(m_if.tc), 0);
      chk_digits("down", exp_c);
    end

    // Directed vectors: rst, en, up, load, load_val -> count, tick, co.
    vecs[0]  = mk(1, 0, 1, 0,  0,  0, 0, 0);
    vecs[1]  = mk(0, 1, 1, 1, 42, 42, 0, 0);
    vecs[2]  = mk(0, 1, 1, 0,  0, 43, 1, 0);
    vecs[3]  = mk(0, 0, 1, 0,  0, 43, 0, 0);
    vecs[4]  = mk(0, 0, 1, 1, 63, 59, 0, 0);
    vecs[5]  = mk(0, 1, 1, 0,  0,  0, 1, 1);
    vecs[6]  = mk(0, 1, 0, 0,  0, 59, 1, 1);
    vecs[7]  = mk(0, 1, 0, 0,  0, 58, 1, 0);
    vecs[8]  = mk(0, 0, 1, 1, 37, 37, 0, 0);
    vecs[9]  = mk(1, 1, 1, 1,  5,  0, 0, 0);
    vecs[10] = mk(0, 1, 0, 0,  0, 59, 1, 1);
    vecs[11] = mk(0, 0, 1, 1, 60, 59, 0, 0);
    vecs[12] = mk(0, 0, 1, 1, 59, 59, 0, 0);
    vecs[13] = mk(0, 0, 0, 1,  0,  0, 0, 0);
    vecs[14] = mk(0, 1, 1, 0,  0,  1, 1, 0);
    vecs[15] = mk(0, 0, 1, 1, 19, 19, 0, 0);
    vecs[16] = mk(0, 1, 1, 0,  0, 20, 1, 0);
    vecs[17] = mk(0, 1, 1, 1, 47, 47, 0, 0);
    vecs[18] = mk(0, 1, 0, 0,  0, 46, 1, 0);
    vecs[19] = mk(0, 0, 1, 1, 10, 10, 0, 0);
    vecs[20] = mk(0, 1, 0, 0,  0,  9, 1, 0);
    vecs[21] = mk(0, 0, 0, 0,  0,  9, 0, 0);

    for (int i = 0; i < NVEC; i++) begin
      m_rst = vecs[i].rst; m_if.en = vecs[i].en; m_if.up = vecs[i].up;
      m_if.load = vecs[i].load; m_if.load_val = vecs[i].lv;
      cyc();
      chk($sformatf("vec%0d.count", i), int'(m_if.count), vecs[i].cnt);
      chk($sformatf("vec%0d.tick", i), int'(m_if.tick), int'(vecs[i].tick));
      chk($sformatf("vec%0d.co", i), int'(m_if.co), int'(vecs[i].co));
      chk($sformatf("vec%0d.tc", i), int'(m_if.tc),
          int'((vecs[i].up && vecs[i].cnt == 59) || (!vecs[i].up && vecs[i].cnt == 0)));
      chk_digits($sformatf("vec%0d", i), vecs[i].cnt);
    end
    m_if.load = 1'b0; m_if.en = 1'b0;

    // DIV=4 prescaler: {rst, en} per cycle; en gap mid-prescale, then reset mid-prescale.
    dpat = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00,
             2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b11, 2'b01, 2'b01, 2'b01};
    d_rst = 1'b1;
    cyc();
    pre = 0; exp_c = 0;
    for (int i = 0; i < 18; i++) begin
      d_rst = dpat[i][1]; d_if.en = dpat[i][0];
      cyc();
      exp_t = 1'b0;
      if (dpat[i][1]) begin
        pre = 0; exp_c = 0;
      end else if (dpat[i][0]) begin
        if (pre == 3) begin
          pre = 0; exp_c = exp_c + 1; exp_t = 1'b1;
        end else begin
          pre = pre + 1;
        end
      end
      chk($sformatf("div4.%0d.count", i), int'(d_if.count), exp_c);
      chk($sformatf("div4.%0d.tick", i), int'(d_if.tick), int'(exp_t));
    end
    // Three enables after the reset must not have stepped; the fourth does.
    d_rst = 1'b0; d_if.en = 1'b1;
    cyc();
    chk("div4.after_rst.count", int'(d_if.count), 1);
    chk("div4.after_rst.tick", int'(d_if.tick), 1);
    d_if.en = 1'b0;

    // Cascade 59:59 -> 00:00.
    c_rst = 1'b1;
    cyc();
    c_rst = 1'b0; s_if.load = 1'b1; s_if.load_val = 6'd59;
    n_if.load = 1'b1; n_if.load_val = 6'd59;
    cyc();
    s_if.load = 1'b0; n_if.load = 1'b0;
    chk("casc.load.sec", int'(s_if.count), 59);
    chk("casc.load.min", int'(n_if.count), 59);
    s_if.en = 1'b1;
    co_pulses = 0;
    cyc();
    s_if.en = 1'b0;
    chk("casc.e1.sec", int'(s_if.count), 0);
    chk("casc.e1.sec_co", int'(s_if.co), 1);
    chk("casc.e1.min", int'(n_if.count), 59);
    co_pulses += int'(n_if.co);
    cyc();
    chk("casc.e2.min", int'(n_if.count), 0);
    chk("casc.e2.sec_co", int'(s_if.co), 0);
    co_pulses += int'(n_if.co);
    for (int i = 0; i < 3; i++) begin
      cyc();
      co_pulses += int'(n_if.co);
    end
    chk("casc.min_co_pulses", co_pulses, 1);
    chk("casc.final.min", int'(n_if.count), 0);
    chk("casc.final.sec", int'(s_if.count), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mod_counter_pd.md
Name: mod_counter_pd

Overview:
- Parametrised modulo-N counter; successor to the fixed mod-60 stopwatch digit counter.
- Adds count enable, an internal prescaler, up/down direction, parallel load and a registered carry/borrow pulse.
- The carry/borrow pulse lets instances cascade, e.g. seconds -> minutes.
- Used by the stopwatch/clock datapath as the generic digit/field counter.

Parameters:
- MODULUS, 60, count range 0..MODULUS-1; must be >= 2.
- WIDTH, 6, width of count/load_val; must satisfy 2^WIDTH >= MODULUS.
- DIV, 1, prescaler ratio: one count step per DIV enabled cycles; must be >= 1.
- PW, 8, prescaler counter width; must satisfy 2^PW >= DIV.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  synchronous active-high reset
- en  input  1  count enable; advances prescaler when high
- up  input  1  direction: 1 = increment, 0 = decrement
- load  input  1  synchronous parallel load strobe
- load_val  input  WIDTH  value to load
- count  output  WIDTH  current count, registered
- tick  output  1  registered; high for the one cycle in which count changed by a step
- co  output  1  registered one-cycle carry (up wrap) or borrow (down wrap) pulse
- tc  output  1  combinational terminal count: (up && count==MODULUS-1) || (!up && count==0)
- bcd_tens  output  4  tens digit of count (see Optional Feature)
- bcd_ones  output  4  ones digit of count (see Optional Feature)

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Priority each rising edge: rst > load > step > hold.
- rst=1: count=0, prescaler=0, tick=0, co=0, bcd_tens=0, bcd_ones=0. Reset mid-prescale discards the partial prescale.
- load=1 (rst=0):
  - count <= load_val if load_val < MODULUS, else MODULUS-1 (saturate).
  - Prescaler cleared; tick=0; co=0.
  - en is ignored in this cycle.
- Prescaler (en=1, no rst/load): if prescaler==DIV-1, prescaler <= 0 and a step occurs; else prescaler increments. With DIV=1 every enabled cycle is a step.
- en=0: prescaler, count and digits hold; tick=0, co=0.
- Step, up=1: count <= (count==MODULUS-1) ? 0 : count+1. co=1 in the same cycle count becomes 0 via wrap.
- Step, down=0 direction (up=0): count <= (count==0) ? MODULUS-1 : count-1. co=1 in the same cycle count becomes MODULUS-1 via wrap.
- tick=1 on every step cycle; co is asserted only together with tick.
- Latency: count, tick and co update on the edge of the step, i.e. one cycle after the final enabled prescale cycle is sampled.
- Changing up between steps takes effect at the next step; the prescaler phase is unaffected.
- If count is ever >= MODULUS (unreachable by design), the next up step wraps to 0 with co=1, and the next down step gives count-1 with no co.
- Cascading: drive the next stage's en from this stage's co, with that stage's DIV=1.

Optional Feature:
- Macro: MOD_COUNTER_BCD_EN.
- Defined:
  - bcd_tens/bcd_ones are registers tracking count in decimal, updated on the same edge as count.
  - Digits are maintained incrementally on steps (ones wraps 9<->0 with tens +/-1; the modulus wrap sets the digits of 0 or MODULUS-1).
  - On load, digits are computed from the loaded (saturated) value.
  - Valid only for MODULUS <= 100; elaboration error otherwise.
- Undefined: bcd_tens and bcd_ones are tied to 4'd0 and no digit logic is synthesised.

Test Plan:
- MODULUS=60, DIV=1, rst=1 one cycle then en=1, up=1 for 61 cycles -> count 0,1..59,0,1; co=1 only on the cycle count returns to 0; tick=1 every cycle.
- up=0 from reset, en=1 -> count 59,58,...; co=1 on the 0->59 transition; tc=1 while count==0 and up=0.
- DIV=4, en=1, up=1 -> count increments every 4th cycle; tick high 1 of 4 cycles. Drop en for 3 cycles mid-prescale -> phase held, resumes exactly.
- load=1 with load_val=42 and en=1 in the same cycle -> count=42, co=0. load_val=63 -> count=59. Next up step from 59 -> 0 with co=1.
- rst asserted together with load and en at count=37 -> count=0, co=0, tick=0. Two instances cascaded (seconds co -> minutes en) at 59:59 -> 00:00, with minutes co pulsing once.
- MOD_COUNTER_BCD_EN defined, MODULUS=60: count 19 -> 20 gives tens=2, ones=0; down wrap 0 -> 59 gives tens=5, ones=9; load 47 gives tens=4, ones=7. Undefined -> both digit outputs stay 0.
